// File: rtl/clk_period_monitor_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | clk_mon_pkg: shared types and helpers for the divided-clock monitor.     |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
package clk_mon_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ARM    = 2'd1,
        MEAS   = 2'd2,
        LOCKED = 2'd3
    } state_t;

    localparam int CNT_W_DEF    = 8;
    localparam int LOCK_CNT_DEF = 4;
    localparam int TIMEOUT_DEF  = 255;

    function automatic logic [31:0] sat_inc(input logic [31:0] v, input logic [31:0] max_v);
        return (v >= max_v) ? max_v : v + 32'd1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/clk_period_monitor_edge_sync.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | edge_sync: 2-FF synchronizer plus delayed copy for rise/fall detection.  |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module edge_sync (
    input  logic clk_in,
    input  logic rst_n,
    input  logic async_in,
    output logic s,
    output logic rise,
    output logic fall
);

    logic r_meta;
    logic r_sync;
    logic r_sync_d;

    always_ff @(posedge clk_in) begin
        if (!rst_n) begin
            r_meta   <= 1'b0;
            r_sync   <= 1'b0;
            r_sync_d <= 1'b0;
        end else begin
            r_meta   <= async_in;
            r_sync   <= r_meta;
            r_sync_d <= r_sync;
        end
    end

    assign s    = r_sync;
    assign rise = r_sync & ~r_sync_d;
    assign fall = ~r_sync & r_sync_d;

endmodule
`default_nettype wire

// File: rtl/clk_period_monitor.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | clk_period_monitor: measures period/high time of a slow wave, locks on.  |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module clk_period_monitor
    import clk_mon_pkg::*;
#(
    parameter int CNT_W    = CNT_W_DEF,
    parameter int LOCK_CNT = LOCK_CNT_DEF,
    parameter int TIMEOUT  = TIMEOUT_DEF
) (
    input  logic             clk_in,
    input  logic             rst_n,
    input  logic             clk_slow,
    input  logic [3:0]       n_expected,
    output logic [CNT_W-1:0] period,
    output logic [CNT_W-1:0] high_time,
    output logic             meas_valid,
    output logic             locked,
    output logic             mismatch,
    output logic             timeout
);

    localparam logic [CNT_W-1:0] c_cnt_max    = '1;
    localparam logic [CNT_W-1:0] c_timeout_m1 = CNT_W'(TIMEOUT - 1);
    localparam logic [3:0]       c_lock_cnt   = 4'(LOCK_CNT);

    logic w_s;
    logic w_rise;
    logic w_fall;

    state_t           r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] r_hcnt;
    logic [CNT_W-1:0] r_idle;
    logic             r_hi_open;
    logic [3:0]       r_match;
    logic [1:0]       r_settle;
    logic [CNT_W-1:0] r_period;
    logic [CNT_W-1:0] r_high_time;
    logic             r_meas_valid;
    logic             r_locked;
    logic             r_mismatch;
    logic             r_timeout;

    logic             w_check_en;
    logic             w_period_ok;
    logic             w_timeout_hit;
    logic [3:0]       w_match_next;

    edge_sync u_edge_sync (
        .clk_in   (clk_in),
        .rst_n    (rst_n),
        .async_in (clk_slow),
        .s        (w_s),
        .rise     (w_rise),
        .fall     (w_fall)
    );

    // A period with no fall seen, or one that saturated, can never match.
    assign w_check_en    = (n_expected >= 4'd2);
    assign w_period_ok   = !r_hi_open && (r_cnt == CNT_W'(n_expected)) && (r_cnt != c_cnt_max);
    assign w_timeout_hit = (r_idle == c_timeout_m1) && !w_rise;
    assign w_match_next  = (r_match >= c_lock_cnt - 4'd1) ? c_lock_cnt : r_match + 4'd1;

    always_ff @(posedge clk_in) begin
        if (!rst_n) begin
            r_state      <= IDLE;
            r_cnt        <= '0;
            r_hcnt       <= '0;
            r_idle       <= '0;
            r_hi_open    <= 1'b0;
            r_match      <= '0;
            r_settle     <= '0;
            r_period     <= '0;
            r_high_time  <= '0;
            r_meas_valid <= 1'b0;
            r_locked     <= 1'b0;
            r_mismatch   <= 1'b0;
            r_timeout    <= 1'b0;
        end else begin
            r_meas_valid <= 1'b0;
            r_mismatch   <= 1'b0;

            // The synchronizer output is only meaningful two cycles after reset.
            if (r_settle != 2'd2) begin
                r_settle <= r_settle + 2'd1;
            end

            if (w_rise || (r_state == IDLE)) begin
                r_idle <= '0;
            end else begin
                r_idle <= CNT_W'(sat_inc(32'(r_idle), 32'(c_cnt_max)));
            end

            case (r_state)
                IDLE: begin
                    if ((r_settle == 2'd2) && !w_s) begin
                        r_state <= ARM;
                    end
                end
                ARM: begin
                    if (w_rise) begin
                        r_state   <= MEAS;
                        r_cnt     <= CNT_W'(1);
                        r_hcnt    <= CNT_W'(1);
                        r_hi_open <= 1'b1;
                        r_timeout <= 1'b0;
                    end else if (w_timeout_hit) begin
                        r_timeout <= 1'b1;
                        r_locked  <= 1'b0;
                        r_match   <= '0;
                        r_state   <= IDLE;
                    end
                end
                MEAS, LOCKED: begin
                    if (w_rise) begin
                        r_period     <= r_cnt;
                        r_meas_valid <= 1'b1;
                        if (r_hi_open) begin
                            r_high_time <= r_cnt;
                        end
                        r_cnt     <= CNT_W'(1);
                        r_hcnt    <= CNT_W'(1);
                        r_hi_open <= 1'b1;
                        if (!w_check_en) begin
                            r_match  <= '0;
                            r_locked <= 1'b0;
                            r_state  <= MEAS;
                        end else if (w_period_ok) begin
                            r_match <= w_match_next;
                            if (w_match_next == c_lock_cnt) begin
                                r_locked <= 1'b1;
                                r_state  <= LOCKED;
                            end
                        end else begin
                            r_mismatch <= 1'b1;
                            r_match    <= '0;
                            r_locked   <= 1'b0;
                            r_state    <= MEAS;
                        end
                    end else if (w_timeout_hit) begin
                        r_timeout <= 1'b1;
                        r_locked  <= 1'b0;
                        r_match   <= '0;
                        r_state   <= IDLE;
                    end else begin
                        r_cnt <= CNT_W'(sat_inc(32'(r_cnt), 32'(c_cnt_max)));
                        if (r_hi_open) begin
                            if (w_fall) begin
                                r_high_time <= r_hcnt;
                                r_hi_open   <= 1'b0;
                            end else begin
                                r_hcnt <= CNT_W'(sat_inc(32'(r_hcnt), 32'(c_cnt_max)));
                            end
                        end
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign period     = r_period;
    assign high_time  = r_high_time;
    assign meas_valid = r_meas_valid;
    assign locked     = r_locked;
    assign mismatch   = r_mismatch;
    assign timeout    = r_timeout;

endmodule
`default_nettype wire

// File: tb/tb_clk_period_monitor.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_clk_period_monitor: event/timestamp reference model plus vectors.     |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module tb_clk_period_monitor;

    localparam int CNT_W    = 4;
    localparam int LOCK_CNT = 4;
    localparam int TIMEOUT  = 15;
    localparam int MAXV     = (1 << CNT_W) - 1;

    logic             clk_in = 1'b0;
    logic             rst_n = 1'b0;
    logic             clk_slow = 1'b0;
    logic [3:0]       n_expected = 4'd0;
    logic [CNT_W-1:0] period;
    logic [CNT_W-1:0] high_time;
    logic             meas_valid;
    logic             locked;
    logic             mismatch;
    logic             timeout;

    clk_period_monitor #(
        .CNT_W    (CNT_W),
        .LOCK_CNT (LOCK_CNT),
        .TIMEOUT  (TIMEOUT)
    ) dut (
        .clk_in     (clk_in),
        .rst_n      (rst_n),
        .clk_slow   (clk_slow),
        .n_expected (n_expected),
        .period     (period),
        .high_time  (high_time),
        .meas_valid (meas_valid),
        .locked     (locked),
        .mismatch   (mismatch),
        .timeout    (timeout)
    );

    always #5 clk_in = ~clk_in;

    int checks = 0;
    int errors = 0;
    int mv_cnt = 0;
    int mm_cnt = 0;
    int since_mv = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            if (errors <= 40)
                $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int imin(input int a, input int b);
        return (a < b) ? a : b;
    endfunction

    // Reference model: works from input sample history and rise/fall timestamps.
    typedef enum int {M_IDLE, M_ARM, M_RUN} mmode_t;
    mmode_t m_mode = M_IDLE;
    int     m_t = 0;
    int     m_last_rise = 0;
    int     m_quiet = 0;
    int     m_matches = 0;
    bit     m_hi_open = 1'b0;
    bit     q[$];
    int     e_period = 0;
    int     e_high = 0;
    bit     e_mv = 1'b0;
    bit     e_locked = 1'b0;
    bit     e_mm = 1'b0;
    bit     e_to = 1'b0;

    task automatic model_timeout();
        e_to      = 1'b1;
        e_locked  = 1'b0;
        m_matches = 0;
        m_mode    = M_IDLE;
    endtask

    task automatic model_edge(input bit v, input bit r);
        bit sv, sp, rise, fall, primed;
        int sz, p;
        if (!r) begin
            q.delete();
            m_mode = M_IDLE; m_matches = 0; m_hi_open = 1'b0; m_t = 0;
            e_period = 0; e_high = 0; e_mv = 1'b0; e_locked = 1'b0; e_mm = 1'b0; e_to = 1'b0;
            return;
        end
        m_t++;
        sz     = q.size();
        primed = (sz >= 2);
        sv     = (sz >= 2) ? q[sz-2] : 1'b0;
        sp     = (sz >= 3) ? q[sz-3] : 1'b0;
        rise   = sv && !sp;
        fall   = !sv && sp;
        e_mv   = 1'b0;
        e_mm   = 1'b0;
        case (m_mode)
            M_IDLE: begin
                if (primed && !sv) begin
                    m_mode  = M_ARM;
                    m_quiet = m_t;
                end
            end
            M_ARM: begin
                if (rise) begin
                    m_mode = M_RUN; m_last_rise = m_t; m_quiet = m_t; m_hi_open = 1'b1; e_to = 1'b0;
                end else if (m_t - m_quiet == TIMEOUT) begin
                    model_timeout();
                end
            end
            M_RUN: begin
                if (rise) begin
                    p = imin(m_t - m_last_rise, MAXV);
                    e_period = p;
                    if (m_hi_open) e_high = p;
                    e_mv = 1'b1;
                    if (n_expected < 2) begin
                        m_matches = 0; e_locked = 1'b0;
                    end else if (!m_hi_open && p == int'(n_expected) && p != MAXV) begin
                        m_matches = imin(m_matches + 1, LOCK_CNT);
                        if (m_matches == LOCK_CNT) e_locked = 1'b1;
                    end else begin
                        e_mm = 1'b1; m_matches = 0; e_locked = 1'b0;
                    end
                    m_last_rise = m_t; m_quiet = m_t; m_hi_open = 1'b1;
                end else if (m_t - m_quiet == TIMEOUT) begin
                    model_timeout();
                end else if (fall && m_hi_open) begin
                    e_high    = imin(m_t - m_last_rise, MAXV);
                    m_hi_open = 1'b0;
                end
            end
            default: m_mode = M_IDLE;
        endcase
        q.push_back(v);
        if (q.size() > 3) void'(q.pop_front());
    endtask

    task automatic step(input logic v);
        clk_slow = v;
        @(posedge clk_in);
        #1;
        model_edge(v, rst_n);
        chk("period",     32'(period),     32'(e_period));
        chk("high_time",  32'(high_time),  32'(e_high));
        chk("meas_valid", 32'(meas_valid), 32'(e_mv));
        chk("locked",     32'(locked),     32'(e_locked));
        chk("mismatch",   32'(mismatch),   32'(e_mm));
        chk("timeout",    32'(timeout),    32'(e_to));
        if (meas_valid === 1'b1) begin mv_cnt++; since_mv = 0; end
        else since_mv++;
        if (mismatch === 1'b1) mm_cnt++;
    endtask

    task automatic wave(input int hi, input int lo, input int reps);
        for (int k = 0; k < reps; k++) begin
            repeat (hi) step(1'b1);
            repeat (lo) step(1'b0);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_period"},    32'(period),     0);
        chk({tag, "_high_time"}, 32'(high_time),  0);
        chk({tag, "_meas_valid"},32'(meas_valid), 0);
        chk({tag, "_locked"},    32'(locked),     0);
        chk({tag, "_mismatch"},  32'(mismatch),   0);
        chk({tag, "_timeout"},   32'(timeout),    0);
    endtask

    typedef struct {
        int hi; int lo; int nexp; int reps;
        int e_per; int e_hi; int e_lock; int e_mv; int e_mm;
    } vec_t;
    vec_t tbl[8];

    initial begin
        int to_at;
        int hi, lo, reps;
        tbl[0] = '{3, 3,  6, 6,  6, 3, 1, 5, 0};
        tbl[1] = '{3, 2,  5, 6,  5, 3, 1, 6, 1};
        tbl[2] = '{3, 2,  6, 1,  5, 3, 0, 1, 1};
        tbl[3] = '{3, 3,  1, 6,  6, 3, 0, 6, 0};
        tbl[4] = '{2, 2,  4, 6,  4, 2, 1, 6, 1};
        tbl[5] = '{1, 6,  7, 6,  7, 1, 1, 6, 1};
        tbl[6] = '{7, 8, 15, 4, 15, 7, 0, 4, 4};
        tbl[7] = '{4, 3,  0, 6,  7, 4, 0, 6, 0};

        rst_n = 1'b0;
        step(1'b0);
        step(1'b0);
        chk_all_zero("reset");
        rst_n = 1'b1;
        repeat (4) step(1'b0);

        for (int i = 0; i < 8; i++) begin
            n_expected = 4'(tbl[i].nexp);
            mv_cnt = 0;
            mm_cnt = 0;
            wave(tbl[i].hi, tbl[i].lo, tbl[i].reps);
            chk($sformatf("vec%0d_period", i),    32'(period),    32'(tbl[i].e_per));
            chk($sformatf("vec%0d_high_time", i), 32'(high_time), 32'(tbl[i].e_hi));
            chk($sformatf("vec%0d_locked", i),    32'(locked),    32'(tbl[i].e_lock));
            chk($sformatf("vec%0d_mv_count", i),  32'(mv_cnt),    32'(tbl[i].e_mv));
            chk($sformatf("vec%0d_mm_count", i),  32'(mm_cnt),    32'(tbl[i].e_mm));
        end

        // Lock, then stop the wave: timeout lands TIMEOUT cycles after the last measurement.
        n_expected = 4'd6;
        wave(3, 3, 6);
        chk("pre_timeout_locked", 32'(locked), 1);
        for (int i = 0; i < 40 && timeout !== 1'b1; i++) step(1'b0);
        chk("timeout_delay", 32'(since_mv), TIMEOUT);
        chk("timeout_locked", 32'(locked), 0);
        wave(3, 3, 6);
        chk("relock_timeout", 32'(timeout), 0);
        chk("relock_locked", 32'(locked), 1);

        // Wave high through reset release must not arm.
        rst_n = 1'b0;
        step(1'b1);
        step(1'b1);
        rst_n = 1'b1;
        mv_cnt = 0;
        repeat (10) step(1'b1);
        chk("high_at_reset_no_mv", 32'(mv_cnt), 0);
        repeat (4) step(1'b0);
        wave(3, 3, 2);
        chk("first_mv_after_two_rises", 32'(mv_cnt), 1);
        wave(3, 3, 5);
        chk("glitch_prelock", 32'(locked), 1);
        mm_cnt = 0;
        wave(2, 2, 1);
        wave(3, 3, 6);
        chk("glitch_mm_count", 32'(mm_cnt), 1);
        chk("glitch_relock", 32'(locked), 1);

        // Checking disabled, then a one-cycle reset mid-stream.
        n_expected = 4'd1;
        wave(3, 3, 4);
        chk("nexp1_period", 32'(period), 6);
        rst_n = 1'b0;
        step(1'b1);
        chk_all_zero("midreset");
        rst_n = 1'b1;
        wave(3, 3, 4);

        // Constant high after arming, then a period longer than TIMEOUT.
        n_expected = 4'd6;
        rst_n = 1'b0;
        step(1'b0);
        rst_n = 1'b1;
        repeat (4) step(1'b0);
        mv_cnt = 0;
        to_at = 0;
        for (int i = 1; i <= 40; i++) begin
            step(1'b1);
            if (timeout === 1'b1 && to_at == 0) to_at = i;
        end
        chk("const_high_timeout_step", 32'(to_at), 18);
        chk("const_high_no_mv", 32'(mv_cnt), 0);
        mv_cnt = 0;
        wave(10, 10, 3);
        chk("long_period_no_mv", 32'(mv_cnt), 0);
        chk("long_period_timeout", 32'(timeout), 1);

        // Randomized bursts against the reference model.
        for (int it = 0; it < 150; it++) begin
            hi   = int'($urandom_range(1, 8));
            lo   = ($urandom_range(0, 9) == 0) ? int'($urandom_range(12, 20)) : int'($urandom_range(1, 8));
            reps = int'($urandom_range(1, 6));
            if ($urandom_range(0, 1) == 1 && hi + lo <= 15) n_expected = 4'(hi + lo);
            else if ($urandom_range(0, 3) == 0) n_expected = 4'($urandom_range(0, 15));
            wave(hi, lo, reps);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #5000000;
        errors++;
        $display("FAIL watchdog: got timeout, expected completion");
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
